// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder <-> program-counter sequencer bus.
// master = decoder side (drives requests), slave = sequencer side.
interface pc_sequencer_if #(
  parameter int program_code_size = 8,
  parameter int offset_width      = 8
);
  logic                         pc_inc;
  logic                         pc_branch;
  logic                         pc_jump;
  logic                         pc_call;
  logic                         pc_ret;
  logic [program_code_size-1:0] pc_target;
  logic [offset_width-1:0]      pc_offset;
  logic [program_code_size-1:0] pc_out;
  logic                         stack_empty;
  logic                         stack_full;
  logic                         stack_error;
  logic                         pc_wrap;

  modport master (
    output pc_inc, pc_branch, pc_jump, pc_call, pc_ret, pc_target, pc_offset,
    input  pc_out, stack_empty, stack_full, stack_error, pc_wrap
  );

  modport slave (
    input  pc_inc, pc_branch, pc_jump, pc_call, pc_ret, pc_target, pc_offset,
    output pc_out, stack_empty, stack_full, stack_error, pc_wrap
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment, signed relative branch,
// absolute jump and an optional hardware call/return stack.
// Optional feature macro: PC_CALL_STACK_EN (defined -> call/ret stack built;
// undefined -> call/ret ignored, stack_empty=1, stack_full=0, stack_error=0).
// Priority: ret > call > jump > branch > inc > hold. All outputs registered.
module pc_sequencer #(
  parameter int                           program_code_size = 8,
  parameter int                           offset_width      = 8,
  parameter int                           stack_depth       = 4,
  parameter logic [program_code_size-1:0] reset_vector      = '0
) (
  input logic             clk,
  input logic             n_reset,
  pc_sequencer_if.slave   bus
);

  typedef logic [program_code_size-1:0] addr_t;

  // Sign-extend the branch offset to address width (signed size cast extends the sign).
  function automatic addr_t sext_offset(input logic signed [offset_width-1:0] off);
    return addr_t'(program_code_size'(off));
  endfunction

  addr_t pc_next;
  logic  wrap_next;

`ifdef PC_CALL_STACK_EN
  localparam int ptr_w = $clog2(stack_depth + 1);
  localparam int idx_w = (stack_depth > 1) ? $clog2(stack_depth) : 1;
  typedef logic [ptr_w-1:0] ptr_t;
  localparam ptr_t ptr_max = ptr_t'(stack_depth);

  addr_t stack_mem [stack_depth];
  ptr_t  ptr;
  ptr_t  ptr_next;
  logic  push;
  logic  err_next;
  addr_t ret_addr;
  addr_t top_of_stack;

  assign ret_addr     = bus.pc_out + addr_t'(1);
  assign top_of_stack = stack_mem[idx_w'(ptr - ptr_t'(1))];
`endif

  // Next-address selection by fixed priority; stack ops gate on pointer state.
  always_comb begin
    pc_next   = bus.pc_out;
    wrap_next = 1'b0;
`ifdef PC_CALL_STACK_EN
    ptr_next  = ptr;
    push      = 1'b0;
    err_next  = 1'b0;
    if (bus.pc_ret) begin
      if (ptr != '0) begin
        pc_next  = top_of_stack;
        ptr_next = ptr - ptr_t'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (bus.pc_call) begin
      if (ptr != ptr_max) begin
        push     = 1'b1;
        pc_next  = bus.pc_target;
        ptr_next = ptr + ptr_t'(1);
      end else begin
        err_next = 1'b1;
      end
    end else
`endif
    if (bus.pc_jump) begin
      pc_next = bus.pc_target;
    end else if (bus.pc_branch) begin
      // Relative to the branch's own address, not address + 1.
      pc_next = bus.pc_out + sext_offset(bus.pc_offset);
    end else if (bus.pc_inc) begin
      pc_next   = bus.pc_out + addr_t'(1);
      wrap_next = &bus.pc_out;
    end
  end

  // Program counter and wrap pulse register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.pc_out  <= reset_vector;
      bus.pc_wrap <= 1'b0;
    end else begin
      bus.pc_out  <= pc_next;
      bus.pc_wrap <= wrap_next;
    end
  end

`ifdef PC_CALL_STACK_EN
  // Stack pointer, flags derived from the next pointer, and error pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ptr             <= '0;
      bus.stack_empty <= 1'b1;
      bus.stack_full  <= 1'b0;
      bus.stack_error <= 1'b0;
    end else begin
      ptr             <= ptr_next;
      bus.stack_empty <= (ptr_next == '0);
      bus.stack_full  <= (ptr_next == ptr_max);
      bus.stack_error <= err_next;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[idx_w'(ptr)] <= ret_addr;
    end
  end
`else
  assign bus.stack_empty = 1'b1;
  assign bus.stack_full  = 1'b0;
  assign bus.stack_error = 1'b0;
`endif

endmodule
